// File: rtl/mem_stage_hs_if.sv
// Bundles for the handshaked MEM stage: EXE-side request, data-memory bus and WB result.
// In each modport pair, the master drives the payload.

interface exe_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_alu_result;
  logic [31:0]       in_store_data;
  logic [31:0]       in_rt_old;
  logic [4:0]        in_wreg;
  logic              in_regwrite;

  modport master (
    output in_valid, in_op, in_addr, in_alu_result, in_store_data,
           in_rt_old, in_wreg, in_regwrite,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_addr, in_alu_result, in_store_data,
           in_rt_old, in_wreg, in_regwrite,
    output in_ready
  );
endinterface

interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

interface wb_if;
  logic        out_valid;
  logic [4:0]  out_wreg;
  logic        out_regwrite;
  logic [31:0] out_wdata;
  logic [1:0]  out_exc;

  modport master (
    output out_valid, out_wreg, out_regwrite, out_wdata, out_exc
  );

  modport slave (
    input  out_valid, out_wreg, out_regwrite, out_wdata, out_exc
  );
endinterface

// File: rtl/mem_stage_hs.sv
// Handshaked MIPS MEM stage: one instruction per transaction, variable-latency data memory,
// big-endian byte lanes, misalignment and bus-timeout traps.

module mem_stage_hs #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic    CLK,
  input  logic    RESET,
  exe_if.slave    exe,
  dmem_if.master  dm,
  wb_if.master    wb
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LWL  = 4'd6,
    OP_LWR  = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SWL  = 4'd11,
    OP_SWR  = 4'd12
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_TIMEOUT  = 2'd2
  } exc_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;

  logic [3:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rt_old_q, rt_old_d;
  logic [4:0]        wreg_q, wreg_d;
  logic              regwrite_q, regwrite_d;

  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_wreg_q, out_wreg_d;
  logic              out_regwrite_q, out_regwrite_d;
  logic [31:0]       out_wdata_q, out_wdata_d;
  logic [1:0]        out_exc_q, out_exc_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic        in_ready;
  logic        xfer;
  logic [1:0]  in_off;
  logic        in_is_mem;
  logic        in_is_store;
  logic        in_misaligned;

  assign in_ready = (state_q == ST_IDLE) && RESET;
  assign xfer     = exe.in_valid && in_ready;
  assign in_off   = exe.in_addr[1:0];

  assign in_is_mem   = (exe.in_op >= OP_LB) && (exe.in_op <= OP_SWR);
  assign in_is_store = (exe.in_op >= OP_SB) && (exe.in_op <= OP_SWR);

  // LWL/LWR/LB/LBU/SB/SWL/SWR accept any offset.
  assign in_misaligned =
      (((exe.in_op == OP_LH) || (exe.in_op == OP_LHU) || (exe.in_op == OP_SH)) && in_off[0]) ||
      (((exe.in_op == OP_LW) || (exe.in_op == OP_SW)) && (in_off != 2'b00));

  // ---------------------------------------------------------------------------
  // Store lane placement (bit3 of be = bits[31:24] = offset 0)
  // ---------------------------------------------------------------------------
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [4:0]  st_shl;
  logic [4:0]  st_shr;

  assign st_shl = {in_off, 3'b000};
  assign st_shr = {~in_off, 3'b000};

  // NOTE: every always_comb output gets a default before the case; a path that
  // leaves a variable unassigned would otherwise infer a latch.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = exe.in_store_data;
    case (exe.in_op)
      OP_SB: begin
        st_be    = 4'b1000 >> in_off;
        st_wdata = {4{exe.in_store_data[7:0]}};
      end
      OP_SH: begin
        st_be    = in_off[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{exe.in_store_data[15:0]}};
      end
      OP_SWL: begin
        st_be    = 4'b1111 >> in_off;
        st_wdata = exe.in_store_data >> st_shl;
      end
      OP_SWR: begin
        st_be    = 4'b1111 << (~in_off);
        st_wdata = exe.in_store_data << st_shr;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  logic [31:0] ld_shl_word;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  ld_shl;
  logic [4:0]  ld_shr;

  assign ld_shl      = {off_q, 3'b000};
  assign ld_shr      = {~off_q, 3'b000};
  // Shifting the addressed byte/half to the top makes lane k land at [31:24].
  assign ld_shl_word = dm.dm_rdata << ld_shl;
  assign ld_byte     = ld_shl_word[31:24];
  assign ld_half     = ld_shl_word[31:16];

  always_comb begin
    ld_data = 32'h0;
    case (op_q)
      OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_data = {24'h0, ld_byte};
      OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU: ld_data = {16'h0, ld_half};
      OP_LW:  ld_data = dm.dm_rdata;
      OP_LWL: ld_data = ld_shl_word | (rt_old_q & ~(32'hFFFF_FFFF << ld_shl));
      OP_LWR: ld_data = (dm.dm_rdata >> ld_shr) | (rt_old_q & ~(32'hFFFF_FFFF >> ld_shr));
      default: ;
    endcase
  end

  logic op_q_is_load;
  assign op_q_is_load = (op_q >= OP_LB) && (op_q <= OP_LWR);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dm_req_d       = dm_req_q;
    dm_we_d        = dm_we_q;
    dm_addr_d      = dm_addr_q;
    dm_be_d        = dm_be_q;
    dm_wdata_d     = dm_wdata_q;
    op_d           = op_q;
    off_d          = off_q;
    rt_old_d       = rt_old_q;
    wreg_d         = wreg_q;
    regwrite_d     = regwrite_q;
    out_valid_d    = 1'b0;
    out_wreg_d     = out_wreg_q;
    out_regwrite_d = out_regwrite_q;
    out_wdata_d    = out_wdata_q;
    out_exc_d      = out_exc_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (in_is_mem && !in_misaligned) begin
            state_d    = ST_ACCESS;
            cnt_d      = '0;
            dm_req_d   = 1'b1;
            dm_we_d    = in_is_store;
            dm_addr_d  = {exe.in_addr[ADDR_W-1:2], 2'b00};
            dm_be_d    = st_be;
            dm_wdata_d = st_wdata;
            op_d       = exe.in_op;
            off_d      = in_off;
            rt_old_d   = exe.in_rt_old;
            wreg_d     = exe.in_wreg;
            regwrite_d = exe.in_regwrite;
          end else if (in_misaligned) begin
            out_valid_d    = 1'b1;
            out_wreg_d     = exe.in_wreg;
            out_regwrite_d = 1'b0;
            out_wdata_d    = exe.in_alu_result;
            out_exc_d      = EXC_MISALIGN;
          end else begin
            out_valid_d    = 1'b1;
            out_wreg_d     = exe.in_wreg;
            out_regwrite_d = exe.in_regwrite;
            out_wdata_d    = exe.in_alu_result;
            out_exc_d      = EXC_NONE;
          end
        end
      end

      ST_ACCESS: begin
        if (dm.dm_ack) begin
          state_d        = ST_IDLE;
          dm_req_d       = 1'b0;
          out_valid_d    = 1'b1;
          out_wreg_d     = wreg_q;
          out_regwrite_d = regwrite_q && op_q_is_load;
          out_wdata_d    = ld_data;
          out_exc_d      = EXC_NONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // TIMEOUT request cycles have elapsed without an acknowledge.
          state_d        = ST_IDLE;
          dm_req_d       = 1'b0;
          out_valid_d    = 1'b1;
          out_wreg_d     = wreg_q;
          out_regwrite_d = 1'b0;
          out_wdata_d    = 32'h0;
          out_exc_d      = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      dm_req_q       <= 1'b0;
      dm_we_q        <= 1'b0;
      dm_addr_q      <= '0;
      dm_be_q        <= 4'h0;
      dm_wdata_q     <= 32'h0;
      op_q           <= OP_NONE;
      off_q          <= 2'b00;
      rt_old_q       <= 32'h0;
      wreg_q         <= 5'd0;
      regwrite_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_wreg_q     <= 5'd0;
      out_regwrite_q <= 1'b0;
      out_wdata_q    <= 32'h0;
      out_exc_q      <= EXC_NONE;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dm_req_q       <= dm_req_d;
      dm_we_q        <= dm_we_d;
      dm_addr_q      <= dm_addr_d;
      dm_be_q        <= dm_be_d;
      dm_wdata_q     <= dm_wdata_d;
      op_q           <= op_d;
      off_q          <= off_d;
      rt_old_q       <= rt_old_d;
      wreg_q         <= wreg_d;
      regwrite_q     <= regwrite_d;
      out_valid_q    <= out_valid_d;
      out_wreg_q     <= out_wreg_d;
      out_regwrite_q <= out_regwrite_d;
      out_wdata_q    <= out_wdata_d;
      out_exc_q      <= out_exc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign exe.in_ready    = in_ready;

  assign dm.dm_req       = dm_req_q;
  assign dm.dm_we        = dm_we_q;
  assign dm.dm_addr      = dm_addr_q;
  assign dm.dm_be        = dm_be_q;
  assign dm.dm_wdata     = dm_wdata_q;

  assign wb.out_valid    = out_valid_q;
  assign wb.out_wreg     = out_wreg_q;
  assign wb.out_regwrite = out_regwrite_q;
  assign wb.out_wdata    = out_wdata_q;
  assign wb.out_exc      = out_exc_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: expected WB results are queued when an instruction is
// sent and compared when out_valid appears; bus-side values are checked in place.

module tb_mem_stage_hs;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_LWL = 4'd6, OP_LWR = 4'd7,
                         OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10, OP_SWL = 4'd11,
                         OP_SWR = 4'd12;

  typedef struct packed {
    logic [4:0]  wreg;
    logic        regwrite;
    logic [1:0]  exc;
    logic        chk_wdata;
    logic [31:0] wdata;
  } exp_t;

  logic CLK;
  logic RESET;

  exe_if  #(.ADDR_W(32)) exe ();
  dmem_if #(.ADDR_W(32)) dm ();
  wb_if                  wb ();

  mem_stage_hs #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .exe   (exe),
    .dm    (dm),
    .wb    (wb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb_q[$];

  logic        ack_en    = 1'b1;
  logic        ack_force = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [4:0] wreg, input logic rw, input logic [1:0] exc,
                              input logic chk, input logic [31:0] wdata);
    exp_t e;
    e.wreg = wreg; e.regwrite = rw; e.exc = exc; e.chk_wdata = chk; e.wdata = wdata;
    return e;
  endfunction

  // Zero-wait memory: acknowledge any request seen at the falling edge.
  initial begin
    dm.dm_ack   = 1'b0;
    dm.dm_rdata = 32'h0;
    forever begin
      @(negedge CLK);
      dm.dm_ack   = (ack_en && (dm.dm_req === 1'b1)) || ack_force;
      dm.dm_rdata = mem_rdata;
    end
  end

  // WB monitor: every out_valid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (wb.out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", {31'd0, wb.out_valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("out_wreg", {27'd0, wb.out_wreg}, {27'd0, e.wreg});
          check("out_regwrite", {31'd0, wb.out_regwrite}, {31'd0, e.regwrite});
          check("out_exc", {30'd0, wb.out_exc}, {30'd0, e.exc});
          if (e.chk_wdata) check("out_wdata", wb.out_wdata, e.wdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one instruction, queues its expected result, and returns at the
  // falling edge after the transfer edge.
  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] alu,
                      input logic [31:0] st, input logic [31:0] rt, input logic [4:0] wreg,
                      input logic rw, input logic [31:0] rdata, input logic push,
                      input exp_t e);
    check("in_ready_before_send", {31'd0, exe.in_ready}, 32'd1);
    exe.in_op         = op;
    exe.in_addr       = addr;
    exe.in_alu_result = alu;
    exe.in_store_data = st;
    exe.in_rt_old     = rt;
    exe.in_wreg       = wreg;
    exe.in_regwrite   = rw;
    exe.in_valid      = 1'b1;
    mem_rdata         = rdata;
    if (push) sb_q.push_back(e);
    @(negedge CLK);
    exe.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge CLK);
      #1;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Checks one store's bus fields in its first request cycle and lets it complete.
  task automatic store_case(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] rt, input logic [3:0] be,
                            input logic [31:0] wdata);
    send(op, addr, 32'h0, rt, 32'h0, 5'd9, 1'b1, 32'h0, 1'b1, mk(5'd9, 1'b0, 2'd0, 1'b0, 32'h0));
    check({tag, "_dm_req"},   {31'd0, dm.dm_req}, 32'd1);
    check({tag, "_dm_we"},    {31'd0, dm.dm_we}, 32'd1);
    check({tag, "_dm_addr"},  dm.dm_addr, {addr[31:2], 2'b00});
    check({tag, "_dm_be"},    {28'd0, dm.dm_be}, {28'd0, be});
    check({tag, "_dm_wdata"}, dm.dm_wdata, wdata);
    wait_done();
  endtask

  task automatic load_case(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rdata,
                           input logic [4:0] wreg, input logic [31:0] result);
    send(op, addr, 32'h0, 32'h0, rt, wreg, 1'b1, rdata, 1'b1, mk(wreg, 1'b1, 2'd0, 1'b1, result));
    wait_done();
  endtask

  initial begin
    int req_cycles;

    RESET = 1'b0;
    exe.in_valid = 1'b0; exe.in_op = 4'd0; exe.in_addr = 32'h0; exe.in_alu_result = 32'h0;
    exe.in_store_data = 32'h0; exe.in_rt_old = 32'h0; exe.in_wreg = 5'd0;
    exe.in_regwrite = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", {31'd0, exe.in_ready}, 32'd0);
    check("rst_dm_req", {31'd0, dm.dm_req}, 32'd0);
    check("rst_out_valid", {31'd0, wb.out_valid}, 32'd0);
    check("rst_out_wdata", wb.out_wdata, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, exe.in_ready}, 32'd1);

    // LB 0x1003: lane 3 byte 0x80 sign-extended, result two cycles after the transfer
    send(OP_LB, 32'h1003, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1122_3380, 1'b1,
         mk(5'd3, 1'b1, 2'd0, 1'b1, 32'hFFFF_FF80));
    check("lb_cycle1_dm_req", {31'd0, dm.dm_req}, 32'd1);
    check("lb_cycle1_dm_we", {31'd0, dm.dm_we}, 32'd0);
    check("lb_cycle1_dm_addr", dm.dm_addr, 32'h0000_1000);
    check("lb_cycle1_in_ready", {31'd0, exe.in_ready}, 32'd0);
    check("lb_cycle1_out_valid", {31'd0, wb.out_valid}, 32'd0);
    @(negedge CLK);
    check("lb_cycle2_out_valid", {31'd0, wb.out_valid}, 32'd1);
    check("lb_cycle2_dm_req", {31'd0, dm.dm_req}, 32'd0);
    wait_done();

    load_case(OP_LBU, 32'h1003, 32'h0, 32'h1122_3380, 5'd4, 32'h0000_0080);
    load_case(OP_LWL, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD, 5'd5, 32'hBBCC_DD44);
    load_case(OP_LWR, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD, 5'd6, 32'h1122_AABB);
    load_case(OP_LH,  32'h3002, 32'h0, 32'hAABB_CCDD, 5'd7, 32'hFFFF_CCDD);
    load_case(OP_LHU, 32'h3000, 32'h0, 32'hAABB_CCDD, 5'd8, 32'h0000_AABB);
    load_case(OP_LW,  32'h3004, 32'h0, 32'hDEAD_BEEF, 5'd10, 32'hDEAD_BEEF);

    store_case("sh",  OP_SH,  32'h2002, 32'hABCD_1234, 4'b0011, 32'h1234_1234);
    store_case("sb",  OP_SB,  32'h2001, 32'h0000_00A5, 4'b0100, 32'hA5A5_A5A5);
    store_case("sw",  OP_SW,  32'h2008, 32'h1122_3344, 4'b1111, 32'h1122_3344);
    store_case("swl", OP_SWL, 32'h2002, 32'h1122_3344, 4'b0011, 32'h0000_1122);
    store_case("swr", OP_SWR, 32'h2001, 32'h1122_3344, 4'b1100, 32'h3344_0000);

    // Misaligned LW and SH: no request, exception next cycle
    send(OP_LW, 32'h4002, 32'h0, 32'h0, 32'h0, 5'd11, 1'b1, 32'h0, 1'b1,
         mk(5'd11, 1'b0, 2'd1, 1'b0, 32'h0));
    check("mis_lw_dm_req", {31'd0, dm.dm_req}, 32'd0);
    check("mis_lw_out_valid", {31'd0, wb.out_valid}, 32'd1);
    check("mis_lw_in_ready", {31'd0, exe.in_ready}, 32'd1);
    wait_done();
    send(OP_SH, 32'h4001, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1, 32'h0, 1'b1,
         mk(5'd12, 1'b0, 2'd1, 1'b0, 32'h0));
    check("mis_sh_dm_req", {31'd0, dm.dm_req}, 32'd0);
    wait_done();

    // Back-to-back NONE ops (op 14 behaves as NONE): one result per cycle
    send(OP_NONE, 32'h0, 32'h0000_0111, 32'h0, 32'h0, 5'd13, 1'b1, 32'h0, 1'b1,
         mk(5'd13, 1'b1, 2'd0, 1'b1, 32'h0000_0111));
    check("none1_out_valid", {31'd0, wb.out_valid}, 32'd1);
    send(4'd14, 32'h0, 32'h0000_0222, 32'h0, 32'h0, 5'd14, 1'b0, 32'h0, 1'b1,
         mk(5'd14, 1'b0, 2'd0, 1'b1, 32'h0000_0222));
    check("none2_out_valid", {31'd0, wb.out_valid}, 32'd1);
    send(OP_NONE, 32'h0, 32'h0000_0333, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0, 1'b1,
         mk(5'd15, 1'b1, 2'd0, 1'b1, 32'h0000_0333));
    check("none3_out_valid", {31'd0, wb.out_valid}, 32'd1);
    check("none3_dm_req", {31'd0, dm.dm_req}, 32'd0);
    wait_done();

    // Timeout: no acknowledge, request held for exactly TIMEOUT=4 cycles
    ack_en = 1'b0;
    send(OP_LW, 32'h6000, 32'h0, 32'h0, 32'h0, 5'd16, 1'b1, 32'h0, 1'b1,
         mk(5'd16, 1'b0, 2'd2, 1'b0, 32'h0));
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (dm.dm_req !== 1'b1) break;
      req_cycles++;
      check("timeout_addr_stable", dm.dm_addr, 32'h0000_6000);
      @(negedge CLK);
    end
    check("timeout_req_cycles", 32'(req_cycles), 32'd4);
    check("timeout_out_valid", {31'd0, wb.out_valid}, 32'd1);
    check("timeout_out_exc", {30'd0, wb.out_exc}, 32'd2);
    wait_done();

    // Late acknowledge while idle: no result
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      check("late_ack_out_valid", {31'd0, wb.out_valid}, 32'd0);
    end
    ack_force = 1'b0;
    @(negedge CLK);
    #1;
    check("late_ack_in_ready", {31'd0, exe.in_ready}, 32'd1);

    // Reset during ACCESS: request abandoned at once
    send(OP_SW, 32'h5000, 32'h0, 32'h5555_AAAA, 32'h0, 5'd17, 1'b0, 32'h0, 1'b0,
         mk(5'd0, 1'b0, 2'd0, 1'b0, 32'h0));
    check("mid_access_dm_req", {31'd0, dm.dm_req}, 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("arst_dm_req", {31'd0, dm.dm_req}, 32'd0);
    check("arst_dm_we", {31'd0, dm.dm_we}, 32'd0);
    check("arst_dm_addr", dm.dm_addr, 32'd0);
    check("arst_dm_be", {28'd0, dm.dm_be}, 32'd0);
    check("arst_dm_wdata", dm.dm_wdata, 32'd0);
    check("arst_out_wreg", {27'd0, wb.out_wreg}, 32'd0);
    check("arst_out_wdata", wb.out_wdata, 32'd0);
    check("arst_out_exc", {30'd0, wb.out_exc}, 32'd0);
    check("arst_in_ready", {31'd0, exe.in_ready}, 32'd0);
    ack_en = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("arst_release_in_ready", {31'd0, exe.in_ready}, 32'd1);

    // Normal operation resumes after reset
    load_case(OP_LW, 32'h7000, 32'h0, 32'hCAFE_F00D, 5'd18, 32'hCAFE_F00D);

    repeat (3) @(negedge CLK);
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Handshaked successor to the single-cycle MEM stage of the MIPS pipeline. It accepts one instruction per transaction from EXE and issues a word-aligned, byte-enabled request to a variable-latency data memory. It holds the pipeline via in_ready until the memory acknowledges, then delivers the aligned and extended load result, or the ALU result, to WB. Misaligned accesses and memory timeouts are trapped.

Parameters:
ADDR_W, 32, address width; dm_addr[1:0] always 0
TIMEOUT, 255, cycles in ACCESS without dm_ack before a bus-error exception; TIMEOUT >= 1
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset, asynchronous, active-low
in_valid  in  1  EXE presents an instruction
in_ready  out  1  stage can accept; high only in IDLE
in_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; 13-15 treated as NONE
in_addr  in  ADDR_W  effective address (ALU result)
in_alu_result  in  32  writeback value for non-load ops
in_store_data  in  32  rt value for stores
in_rt_old  in  32  current rt value, merged by LWL/LWR
in_wreg  in  5  destination register
in_regwrite  in  1  instruction writes a register
dm_req  out  1  memory request
dm_we  out  1  1 = write
dm_addr  out  ADDR_W  word-aligned address
dm_be  out  4  byte enables; bit3 = bits[31:24] = address offset 0 (big-endian)
dm_wdata  out  32  write data, lane-positioned
dm_ack  in  1  memory completes the request this cycle
dm_rdata  in  32  read word, valid when dm_ack
out_valid  out  1  one-cycle pulse: result for WB
out_wreg  out  5  destination register
out_regwrite  out  1  write enable to the register file
out_wdata  out  32  writeback data
out_exc  out  2  0 none, 1 misaligned, 2 timeout; valid with out_valid

Behaviour:
- Reset (async, RESET low): state IDLE, counter 0. dm_req=0, dm_we=0, dm_addr=0, dm_be=0, dm_wdata=0, out_valid=0, out_regwrite=0, out_wreg=0, out_wdata=0, out_exc=0. A request in flight is abandoned; dm_req drops immediately.
- FSM states: IDLE, ACCESS. in_ready = (state==IDLE) && RESET.
- Transfer into the stage: in_valid && in_ready at a rising edge.
- Non-memory op (NONE): next cycle out_valid=1, out_wdata=in_alu_result, out_regwrite=in_regwrite, out_exc=0. State stays IDLE, so throughput is 1 instruction per cycle.
- Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. No memory request is issued. Next cycle out_valid=1, out_exc=1, out_regwrite=0. State stays IDLE.
- Aligned memory op: go to ACCESS. From the next cycle, dm_req=1 with dm_addr={addr[ADDR_W-1:2],2'b00}, and dm_we/dm_be/dm_wdata registered. All four are held stable until dm_ack is sampled high.
- ACCESS, dm_ack=1: dm_req drops the same edge. Next cycle out_valid=1, out_exc=0, out_regwrite = in_regwrite for loads and 0 for stores. State returns to IDLE. Minimum memory-op latency is 2 cycles from transfer to out_valid, with a zero-wait memory.
- ACCESS, counter reaches TIMEOUT without dm_ack: drop dm_req, emit out_valid with out_exc=2 and out_regwrite=0, return to IDLE. The counter clears on entry to ACCESS.
- dm_ack while in IDLE is ignored.
- Byte offset k = addr[1:0]:
  - SB: be = 4'b1000>>k; wdata = store byte replicated on all lanes.
  - SH: be = 1100 (k=0) or 0011 (k=2); wdata = half replicated.
  - SW: be = 1111.
  - SWL: be = 4'b1111>>k; wdata = rt>>(8k).
  - SWR: be = (4'b1111<<(3-k)) & 4'hF; wdata = rt<<(8(3-k)).
- Loads, with M = dm_rdata:
  - LB/LBU: byte at lane k (k=0 → M[31:24]), sign- or zero-extended.
  - LH/LHU: k=0 → M[31:16], k=2 → M[15:0], sign- or zero-extended.
  - LW: M.
  - LWL: (M<<8k) | (rt_old & ~(32'hFFFFFFFF<<8k)).
  - LWR: (M>>8(3-k)) | (rt_old & ~(32'hFFFFFFFF>>8(3-k))).
- dm_we=1 for ops 8-12, 0 for loads.
- LWL and LWR are never misaligned.

Test Plan:
- Reset held low mid-ACCESS with dm_req=1 → dm_req=0 within the same cycle, all outputs 0; after release, in_ready=1.
- LB at addr 0x1003, zero-wait ack with dm_rdata=0x11223380 → out_wdata=0xFFFFFF80, out_regwrite=1, out_valid 2 cycles after transfer. LBU at the same address → 0x00000080.
- SH at 0x2002 with rt=0xABCD1234 → dm_be=0011, dm_wdata=0x12341234, dm_we=1; out_regwrite=0 after ack.
- LWL at 0x3001 with dm_rdata=0xAABBCCDD, rt_old=0x11223344 → 0xBBCCDD44. LWR at 0x3001 → 0x1122AABB.
- LW at 0x4002 → no dm_req, out_exc=1, out_regwrite=0. Back-to-back NONE ops → out_valid high every cycle with in_ready=1.
- TIMEOUT=4 with dm_ack held low → dm_req high for exactly 4 cycles, then out_exc=2; a late dm_ack arriving in IDLE produces no out_valid.
